// File: rtl/param_calculator.sv
`default_nettype none
// ============================================================================
// Module   : param_calculator
// Purpose  : Switch/button driven calculator. Takes operands A and B from the
//            switch bus (each confirmed with SCEN), then an operator from the
//            push-buttons. ADD/SUB take one cycle. MUL (shift-add) and DIV
//            (restoring) work on magnitudes, one bit per cycle, and take
//            exactly WIDTH cycles. Both unsigned and two's-complement modes
//            are supported.
// Ports    : Clk, Reset_n (async, active-low)
//            In[WIDTH]           operand switch bus
//            SCEN                confirm pulse
//            ButU/ButD/ButL/ButR ADD/SUB/MUL/DIV select pulses
//            C[WIDTH]            result (quotient for DIV)
//            Rem[WIDTH]          DIV remainder, 0 for other ops
//            Flag                overflow
//            Busy, Done          MUL/DIV in progress, result valid
//            State[10]           one-hot state
// Revision : 1.0 - initial parametrised release
// ============================================================================
module param_calculator #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] In,
  input  logic             SCEN,
  input  logic             ButU,
  input  logic             ButD,
  input  logic             ButL,
  input  logic             ButR,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Rem,
  output logic             Flag,
  output logic             Busy,
  output logic             Done,
  output logic [9:0]       State
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [WIDTH-1:0]   c_min      = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [9:0] c_st_initial = 10'b00_0000_0001;
  localparam logic [9:0] c_st_get_a   = 10'b00_0000_0010;
  localparam logic [9:0] c_st_get_b   = 10'b00_0000_0100;
  localparam logic [9:0] c_st_get_op  = 10'b00_0000_1000;
  localparam logic [9:0] c_st_add     = 10'b00_0001_0000;
  localparam logic [9:0] c_st_sub     = 10'b00_0010_0000;
  localparam logic [9:0] c_st_mul     = 10'b00_0100_0000;
  localparam logic [9:0] c_st_div     = 10'b00_1000_0000;
  localparam logic [9:0] c_st_err     = 10'b01_0000_0000;
  localparam logic [9:0] c_st_done    = 10'b10_0000_0000;

  logic [9:0]         r_state, w_state_next;
  logic [WIDTH-1:0]   r_a, r_b, r_c, r_rem;
  logic               r_flag;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand;  // MUL product accumulator, shifted multiplicand
  logic [WIDTH-1:0]   r_mplr;          // MUL multiplier, consumed LSB first
  logic [WIDTH-1:0]   r_quo, r_racc;   // DIV dividend->quotient shift reg, partial remainder
  logic [WIDTH-1:0]   r_dvs;           // DIV divisor magnitude

  // ---------------- operand signs and magnitudes ----------------
  logic             w_a_neg, w_b_neg, w_res_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_neg   = (SIGNED != 0) && r_a[WIDTH-1];
  assign w_b_neg   = (SIGNED != 0) && r_b[WIDTH-1];
  assign w_res_neg = w_a_neg ^ w_b_neg;
  assign w_a_mag   = w_a_neg ? -r_a : r_a;
  assign w_b_mag   = w_b_neg ? -r_b : r_b;

  // ---------------- ADD / SUB ----------------
  logic [WIDTH:0]   w_sum, w_dif;
  logic             w_add_ovf, w_sub_ovf;
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif = {1'b0, r_a} - {1'b0, r_b};
  always_comb begin
    if (SIGNED != 0) begin
      w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
    end else begin
      w_add_ovf = w_sum[WIDTH];
      w_sub_ovf = w_dif[WIDTH];  // borrow, i.e. A < B
    end
  end

  // ---------------- MUL ----------------
  logic [2*WIDTH-1:0] w_acc_next, w_prod;
  logic               w_mul_ovf;
  assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : {(2*WIDTH){1'b0}});
  assign w_prod     = w_res_neg ? -w_acc_next : w_acc_next;
  // Signed: representable iff the top WIDTH+1 bits are a pure sign extension.
  assign w_mul_ovf  = (SIGNED != 0)
                    ? !((&w_prod[2*WIDTH-1:WIDTH-1]) || (~|w_prod[2*WIDTH-1:WIDTH-1]))
                    : (|w_acc_next[2*WIDTH-1:WIDTH]);

  // ---------------- DIV ----------------
  logic [WIDTH:0]   w_shift, w_trial;
  logic [WIDTH-1:0] w_racc_next, w_quo_next, w_q_final, w_r_final;
  logic             w_div_ovf;
  assign w_shift     = {r_racc, r_quo[WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, r_dvs};
  // A non-negative trial keeps the subtraction; otherwise restore.
  assign w_racc_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_q_final   = w_res_neg ? -w_quo_next : w_quo_next;
  assign w_r_final   = w_a_neg ? -w_racc_next : w_racc_next;
  // MIN / -1: magnitude quotient is 2^(W-1), which already reads back as MIN.
  assign w_div_ovf   = (SIGNED != 0) && (r_a == c_min) && (&r_b);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= c_st_initial;
    else          r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_initial: if (SCEN) w_state_next = c_st_get_a;
      c_st_get_a:   if (SCEN) w_state_next = c_st_get_b;
      c_st_get_b:   if (SCEN) w_state_next = c_st_get_op;
      c_st_get_op: begin
        if (ButU)      w_state_next = c_st_add;
        else if (ButD) w_state_next = c_st_sub;
        else if (ButL) w_state_next = c_st_mul;
        else if (ButR) w_state_next = (r_b == '0) ? c_st_err : c_st_div;
      end
      c_st_add, c_st_sub: w_state_next = c_st_done;
      c_st_mul, c_st_div: if (r_cnt == '0) w_state_next = c_st_done;
      c_st_err, c_st_done: if (SCEN) w_state_next = c_st_initial;
      default: w_state_next = c_st_initial;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    State = r_state;
    Busy  = r_state[6] | r_state[7];
    Done  = r_state[9];
    C     = r_c;
    Rem   = r_rem;
    Flag  = r_flag;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_rem   <= '0;
      r_flag  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_quo   <= '0;
      r_racc  <= '0;
      r_dvs   <= '0;
    end else begin
      case (r_state)
        c_st_initial: r_flag <= 1'b0;
        c_st_get_a:   r_a    <= In;
        c_st_get_b:   r_b    <= In;
        c_st_get_op: begin
          if (w_state_next == c_st_mul) begin
            r_cnt   <= c_cnt_load;
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplr  <= w_b_mag;
          end else if (w_state_next == c_st_div) begin
            r_cnt   <= c_cnt_load;
            r_racc  <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
          end else if (w_state_next == c_st_err) begin
            r_c    <= '0;
            r_rem  <= '0;
            r_flag <= 1'b0;
          end
        end
        c_st_add: begin
          r_c    <= w_sum[WIDTH-1:0];
          r_rem  <= '0;
          r_flag <= w_add_ovf;
        end
        c_st_sub: begin
          r_c    <= w_dif[WIDTH-1:0];
          r_rem  <= '0;
          r_flag <= w_sub_ovf;
        end
        c_st_mul: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt - c_cnt_one;
          if (r_cnt == '0) begin
            r_c    <= w_prod[WIDTH-1:0];
            r_rem  <= '0;
            r_flag <= w_mul_ovf;
          end
        end
        c_st_div: begin
          r_racc <= w_racc_next;
          r_quo  <= w_quo_next;
          r_cnt  <= r_cnt - c_cnt_one;
          if (r_cnt == '0) begin
            r_c    <= w_q_final;
            r_rem  <= w_r_final;
            r_flag <= w_div_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_calculator.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_calculator
// Purpose  : Self-checking bench for param_calculator. One unsigned and one
//            signed instance share the same stimulus; each vector names the
//            instance whose results it checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_param_calculator;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic [W-1:0] In;
  logic         SCEN, ButU, ButD, ButL, ButR;

  logic [W-1:0] c_u, rem_u, c_s, rem_s;
  logic         flag_u, busy_u, done_u, flag_s, busy_s, done_s;
  logic [9:0]   state_u, state_s;

  always #5 Clk = ~Clk;

  param_calculator #(.WIDTH(W), .SIGNED(0)) u_dut_u (
    .Clk(Clk), .Reset_n(Reset_n), .In(In), .SCEN(SCEN),
    .ButU(ButU), .ButD(ButD), .ButL(ButL), .ButR(ButR),
    .C(c_u), .Rem(rem_u), .Flag(flag_u), .Busy(busy_u), .Done(done_u), .State(state_u)
  );

  param_calculator #(.WIDTH(W), .SIGNED(1)) u_dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .In(In), .SCEN(SCEN),
    .ButU(ButU), .ButD(ButD), .ButL(ButL), .ButR(ButR),
    .C(c_s), .Rem(rem_s), .Flag(flag_s), .Busy(busy_s), .Done(done_s), .State(state_s)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         sgn;   // 1: check the signed instance
    logic [15:0] a;
    logic [15:0] b;
    int         op;    // 0 ADD, 1 SUB, 2 MUL, 3 DIV
    logic [15:0] c;
    logic [15:0] rem;
    bit         flag;
    int         cyc;   // cycles spent in the operation state
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input int op);
    ButU = (op == 0);
    ButD = (op == 1);
    ButL = (op == 2);
    ButR = (op == 3);
  endtask

  task automatic release_buttons;
    ButU = 1'b0; ButD = 1'b0; ButL = 1'b0; ButR = 1'b0;
  endtask

  // From INITIAL: confirm into GET_A, capture a, capture b, land in GET_OP.
  task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
    SCEN = 1'b1;
    tick;
    In = a;
    tick;
    In = b;
    tick;
    SCEN = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int nb;
    logic [15:0] c, rem;
    logic flag, done;
    load_ops(v.a, v.b);
    press(v.op);
    tick;
    release_buttons;
    n  = 0;
    nb = 0;
    while (!done_u && n < 64) begin
      n++;
      if (v.sgn ? busy_s : busy_u) nb++;
      tick;
    end
    c    = v.sgn ? c_s    : c_u;
    rem  = v.sgn ? rem_s  : rem_u;
    flag = v.sgn ? flag_s : flag_u;
    chk($sformatf("v%0d cycles", idx), n, v.cyc);
    chk($sformatf("v%0d busy", idx), nb, (v.op >= 2) ? v.cyc : 0);
    chk($sformatf("v%0d C", idx), c, v.c);
    chk($sformatf("v%0d Rem", idx), rem, v.rem);
    chk($sformatf("v%0d Flag", idx), flag, v.flag);
    tick;  // stay in DONE one more cycle; results must hold
    c    = v.sgn ? c_s  : c_u;
    done = v.sgn ? done_s : done_u;
    chk($sformatf("v%0d C hold", idx), c, v.c);
    chk($sformatf("v%0d Done hold", idx), done, 1'b1);
    SCEN = 1'b1;
    tick;
    SCEN = 1'b0;
    chk($sformatf("v%0d back to INITIAL", idx), v.sgn ? state_s : state_u, 10'h001);
  endtask

  initial begin
    //          sgn  a         b        op  c         rem      flag cyc
    vecs[0]  = '{1'b0, 16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[1]  = '{1'b0, 16'd100,  16'd200,  2, 16'h4E20, 16'h0000, 1'b0, 16};
    vecs[2]  = '{1'b0, 16'd300,  16'd300,  2, 16'h5F90, 16'h0000, 1'b1, 16};
    vecs[3]  = '{1'b0, 16'd1000, 16'd7,    3, 16'd142,  16'd6,    1'b0, 16};
    vecs[4]  = '{1'b1, 16'hFFF9, 16'h0002, 3, 16'hFFFD, 16'hFFFF, 1'b0, 16};
    vecs[5]  = '{1'b1, 16'h8000, 16'hFFFF, 3, 16'h8000, 16'h0000, 1'b1, 16};
    vecs[6]  = '{1'b1, 16'h8000, 16'h0001, 1, 16'h7FFF, 16'h0000, 1'b1, 1};
    vecs[7]  = '{1'b1, 16'hFFFD, 16'h0005, 2, 16'hFFF1, 16'h0000, 1'b0, 16};
    vecs[8]  = '{1'b0, 16'h0003, 16'h0005, 1, 16'hFFFE, 16'h0000, 1'b1, 1};
    vecs[9]  = '{1'b1, 16'h7FFF, 16'h0001, 0, 16'h8000, 16'h0000, 1'b1, 1};
    vecs[10] = '{1'b0, 16'h1234, 16'h1111, 0, 16'h2345, 16'h0000, 1'b0, 1};
    vecs[11] = '{1'b1, 16'h0100, 16'h0100, 2, 16'h0000, 16'h0000, 1'b1, 16};
    vecs[12] = '{1'b0, 16'hFFFF, 16'h0010, 3, 16'h0FFF, 16'h000F, 1'b0, 16};
    vecs[13] = '{1'b1, 16'h0007, 16'hFFFE, 3, 16'hFFFD, 16'h0001, 1'b0, 16};
    vecs[14] = '{1'b0, 16'h0005, 16'h0003, 1, 16'h0002, 16'h0000, 1'b0, 1};
    vecs[15] = '{1'b1, 16'hFF80, 16'h0100, 2, 16'h8000, 16'h0000, 1'b0, 16};

    Reset_n = 1'b0;
    In      = '0;
    SCEN    = 1'b0;
    release_buttons;
    repeat (3) tick;
    chk("reset State", state_u, 10'h001);
    chk("reset State signed", state_s, 10'h001);
    chk("reset C", c_u, 16'h0000);
    chk("reset Rem", rem_u, 16'h0000);
    chk("reset Flag/Busy/Done", {flag_u, busy_u, done_u}, 3'b000);
    Reset_n = 1'b1;
    tick;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Divide by zero: GET_OP, then ERR on the next edge with cleared results.
    load_ops(16'd5, 16'd0);
    chk("err in GET_OP", state_u, 10'h008);
    press(3);
    tick;
    release_buttons;
    chk("err State", state_u, 10'h100);
    chk("err C", c_u, 16'h0000);
    chk("err Rem/Flag/Done", {rem_u, flag_u, done_u}, 18'h0);
    tick;
    chk("err holds", state_u, 10'h100);
    SCEN = 1'b1;
    tick;
    SCEN = 1'b0;
    chk("err to INITIAL", state_u, 10'h001);

    // Button priority U > D > L > R.
    load_ops(16'h0010, 16'h0003);
    ButU = 1'b1; ButL = 1'b1;
    tick;
    release_buttons;
    chk("prio U+L State", state_u, 10'h010);
    tick;
    chk("prio U+L C", c_u, 16'h0013);
    SCEN = 1'b1; tick; SCEN = 1'b0;
    load_ops(16'h0009, 16'h0004);
    ButD = 1'b1; ButL = 1'b1; ButR = 1'b1;
    tick;
    release_buttons;
    chk("prio D+L+R State", state_u, 10'h020);
    tick;
    chk("prio D+L+R C", c_u, 16'h0005);
    SCEN = 1'b1; tick; SCEN = 1'b0;

    // INITIAL clears a leftover Flag and ignores buttons.
    run_vec(vecs[0], 100);
    ButU = 1'b1;
    tick;
    release_buttons;
    chk("INITIAL clears Flag", flag_u, 1'b0);
    chk("INITIAL ignores buttons", state_u, 10'h001);

    // Asynchronous reset in DIV cycle 5; SCEN during DIV is ignored.
    load_ops(16'd1000, 16'd7);
    press(3);
    tick;
    release_buttons;
    SCEN = 1'b1;
    tick;
    SCEN = 1'b0;
    repeat (3) tick;
    chk("DIV cycle 5 busy", {state_u, busy_u}, {10'h080, 1'b1});
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async reset State", state_u, 10'h001);
    chk("async reset C/Rem", {c_u, rem_u}, 32'h0);
    chk("async reset Busy", busy_u, 1'b0);
    tick;
    Reset_n = 1'b1;
    tick;
    run_vec(vecs[3], 103);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
